l1_icache_multiword: RTL



---
 rtl/l1_icache_multiword_pkg.sv | 36 +++
 rtl/l1_icache_refill_ctrl.sv | 114 +++++++++++
 rtl/l1_icache_multiword.sv | 97 +++++++++
 3 files changed

// File: rtl/l1_icache_multiword_pkg.sv
`timescale 1ns/1ps
// Shared definitions for the multi-word L1 instruction cache.
// Holds the refill FSM state encoding, address-split constants and
// helpers that derive line geometry from the cache parameters.
package l1_icache_multiword_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    REFILL    = 2'd1,
    FILL_DONE = 2'd2
  } state_e;

  localparam int ADDR_WIDTH = 32;
  localparam int WORD_LSB   = 2;   // instructions are 32-bit words
  localparam int DEF_OFFSET_WIDTH = 4;
  localparam int DEF_INDEX_WIDTH  = 6;

  // Instruction words held in one line.
  function automatic int words_per_line(input int offset_width);
    return 2 ** (offset_width - WORD_LSB);
  endfunction

  // Address bits left over for the tag.
  function automatic int tag_width(input int index_width, input int offset_width);
    return ADDR_WIDTH - index_width - offset_width;
  endfunction

  // Refill word counter width; never narrower than one bit.
  function automatic int cnt_width(input int offset_width);
    return (offset_width - WORD_LSB < 1) ? 1 : offset_width - WORD_LSB;
  endfunction

  localparam int WORDS_PER_LINE = words_per_line(DEF_OFFSET_WIDTH);
  localparam int TAG_WIDTH      = tag_width(DEF_INDEX_WIDTH, DEF_OFFSET_WIDTH);

endpackage

// File: rtl/l1_icache_refill_ctrl.sv
`timescale 1ns/1ps
// Refill controller: latches the missing line, walks its words out of the MMU.
// Latency: one REFILL cycle minimum per word, then one FILL_DONE cycle.
// Backpressure: each word request is held stable until mmu_mem_ready.
module l1_icache_refill_ctrl
  import l1_icache_multiword_pkg::*;
#(
  parameter int OFFSET_WIDTH = 4,
  parameter int INDEX_WIDTH  = 6,
  localparam int CNT_W = cnt_width(OFFSET_WIDTH),
  localparam int TAG_W = tag_width(INDEX_WIDTH, OFFSET_WIDTH)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cpu_req,
  input  logic              cpu_hit,
  input  logic [31:0]       cpu_address,
  input  logic              invalidate,
  input  logic              mmu_mem_ready,
  output logic              mmu_read_req,
  output logic [31:0]       mmu_address,
  output logic              in_idle,
  output logic              data_we,
  output logic [CNT_W-1:0]  wr_word,
  output logic              tag_we,
  output logic [INDEX_WIDTH-1:0] refill_index,
  output logic [TAG_W-1:0]  refill_tag,
  output logic              valid_set,
  output logic              valid_clr_all
);

  localparam int WPL = words_per_line(OFFSET_WIDTH);
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPL - 1);
  localparam logic [31:0] OFF_MASK = 32'((1 << OFFSET_WIDTH) - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      base_q, base_d;
  logic             abort_q, abort_d;

  // State, counter, latched line base and abort flag registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      base_q  <= '0;
      abort_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      abort_q <= abort_d;
    end
  end

  // Next-state logic plus array write strobes and valid-bit controls.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    abort_d       = abort_q;
    mmu_read_req  = 1'b0;
    data_we       = 1'b0;
    tag_we        = 1'b0;
    valid_set     = 1'b0;
    valid_clr_all = 1'b0;
    case (state_q)
      IDLE: begin
        // Lookup this cycle still sees the old valid bits; clear takes effect next edge.
        valid_clr_all = invalidate;
        if (cpu_req && !cpu_hit) begin
          base_d  = cpu_address & ~OFF_MASK;
          cnt_d   = '0;
          state_d = REFILL;
        end
      end
      REFILL: begin
        mmu_read_req = 1'b1;
        if (invalidate) abort_d = 1'b1;
        if (mmu_mem_ready) begin
          data_we = 1'b1;
          if (cnt_q == LAST_WORD) begin
            // An invalidate seen at any point of the refill keeps the line invalid.
            tag_we    = 1'b1;
            valid_set = !(abort_q || invalidate);
            state_d   = FILL_DONE;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      FILL_DONE: begin
        // Deferred invalidate lands here, as the cache returns to IDLE.
        valid_clr_all = abort_q || invalidate;
        abort_d       = 1'b0;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word address of the current refill beat; zero outside REFILL.
  always_comb begin
    mmu_address = '0;
    if (state_q == REFILL)
      mmu_address = base_q + {{(ADDR_WIDTH - CNT_W - WORD_LSB){1'b0}}, cnt_q, 2'b00};
  end

  assign in_idle      = (state_q == IDLE);
  assign wr_word      = cnt_q;
  assign refill_index = base_q[OFFSET_WIDTH +: INDEX_WIDTH];
  assign refill_tag   = base_q[OFFSET_WIDTH + INDEX_WIDTH +: TAG_W];

endmodule

// File: rtl/l1_icache_multiword.sv
`timescale 1ns/1ps
// Direct-mapped L1 instruction cache with multi-word lines and fence.i invalidate.
// Latency: hits return in the request cycle; misses take sum(MMU waits) + 2 cycles.
// Backpressure: cpu_ready low while refilling; MMU beats stall on mmu_mem_ready.
module l1_icache_multiword
  import l1_icache_multiword_pkg::*;
#(
  parameter int OFFSET_WIDTH = 4,
  parameter int INDEX_WIDTH  = 6
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cpu_req,
  input  logic [31:0] cpu_address,
  input  logic        invalidate,
  output logic        cpu_ready,
  output logic [31:0] data_out,
  output logic        cache_miss,
  output logic        mmu_read_req,
  output logic [31:0] mmu_address,
  input  logic        mmu_mem_ready,
  input  logic [31:0] mmu_data_out
);

  localparam int WPL   = words_per_line(OFFSET_WIDTH);
  localparam int TAG_W = tag_width(INDEX_WIDTH, OFFSET_WIDTH);
  localparam int CNT_W = cnt_width(OFFSET_WIDTH);
  localparam int LINES = 2 ** INDEX_WIDTH;
  localparam logic [31:0] WORD_MASK = 32'(WPL - 1);

  // Tag and data storage carry no reset; the valid vector gates them.
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WPL];
  logic [LINES-1:0] valid_q, valid_d;

  logic [TAG_W-1:0]       cpu_tag;
  logic [INDEX_WIDTH-1:0] cpu_index;
  logic [CNT_W-1:0]       cpu_word;
  logic                   hit;

  logic                   in_idle, data_we, tag_we, valid_set, valid_clr_all;
  logic [CNT_W-1:0]       wr_word;
  logic [INDEX_WIDTH-1:0] refill_index;
  logic [TAG_W-1:0]       refill_tag;

  assign cpu_tag   = cpu_address[OFFSET_WIDTH + INDEX_WIDTH +: TAG_W];
  assign cpu_index = cpu_address[OFFSET_WIDTH +: INDEX_WIDTH];
  assign cpu_word  = CNT_W'((cpu_address >> WORD_LSB) & WORD_MASK);

  assign hit        = valid_q[cpu_index] && (tag_mem[cpu_index] == cpu_tag);
  assign cache_miss = cpu_req && !hit;
  assign cpu_ready  = in_idle && cpu_req && hit;
  assign data_out   = data_mem[cpu_index][cpu_word];

  l1_icache_refill_ctrl #(
    .OFFSET_WIDTH (OFFSET_WIDTH),
    .INDEX_WIDTH  (INDEX_WIDTH)
  ) u_refill_ctrl (
    .clk           (clk),
    .reset_n       (reset_n),
    .cpu_req       (cpu_req),
    .cpu_hit       (hit),
    .cpu_address   (cpu_address),
    .invalidate    (invalidate),
    .mmu_mem_ready (mmu_mem_ready),
    .mmu_read_req  (mmu_read_req),
    .mmu_address   (mmu_address),
    .in_idle       (in_idle),
    .data_we       (data_we),
    .wr_word       (wr_word),
    .tag_we        (tag_we),
    .refill_index  (refill_index),
    .refill_tag    (refill_tag),
    .valid_set     (valid_set),
    .valid_clr_all (valid_clr_all)
  );

  // Refill beats write the line storage in place.
  always_ff @(posedge clk) begin
    if (data_we) data_mem[refill_index][wr_word] <= mmu_data_out;
    if (tag_we)  tag_mem[refill_index] <= refill_tag;
  end

  // Valid vector: global clear from invalidate, single-bit set on refill completion.
  always_comb begin
    valid_d = valid_q;
    if (valid_clr_all) valid_d = '0;
    if (valid_set)     valid_d[refill_index] = 1'b1;
  end

  // Valid bits reset asynchronously so a refill cut short by reset stays invalid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) valid_q <= '0;
    else          valid_q <= valid_d;
  end

endmodule
